uart_frame_assembler: RTL and testbench

UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

---
 rtl/uart_frame_assembler_pkg.sv | 35 +++
 rtl/frame_timeout_timer.sv | 36 +++
 rtl/uart_frame_assembler.sv | 187 ++++++++++++++++++
 tb/tb_uart_frame_assembler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_assembler_pkg.sv
// Shared definitions for the UART frame assembler.
// Holds the frame geometry, the default sync marker, the opcode encodings,
// the assembler state enumeration and a small state-classification helper.
package uart_frame_assembler_pkg;

  localparam int FRAME_W       = 66;
  localparam int OPCODE_W      = 2;
  localparam int OPERAND_W     = 32;
  localparam int PAYLOAD_BYTES = 8;
  localparam int BYTE_CNT_W    = $clog2(PAYLOAD_BYTES);

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Opcode encodings carried in the low two bits of the opcode byte.
  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_t;

  // States in which an inter-byte timeout is being watched.
  function automatic logic is_frame_state(input state_t s);
    return (s == ST_OPCODE) || (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer.
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   clear        - zero the count (a byte arrived, or no frame in progress)
//   enable       - count idle cycles while a frame is in progress
//   expired      - combinational; high in the cycle the count sits at
//                  TIMEOUT_CYCLES-1 with no clear, so the registered error
//                  lands exactly TIMEOUT_CYCLES cycles after the last byte
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;

  // clear has priority so a byte arriving on the expiry cycle wins.
  assign expired = enable && !clear && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clear || expired) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles 11-byte UART frames into a 66-bit command word.
// Wire format: SYNC, opcode, operand_a[31:0] MSB first, operand_b[31:0]
// MSB first, checksum (XOR of opcode and the 8 operand bytes).
// Ports:
//   clk, reset               - clock and asynchronous active-high reset
//   rx_data, rx_valid        - byte stream from the UART receiver
//   frame, frame_valid       - checked word {opcode, operand_a, operand_b}
//   frame_ready              - consumer accept; transfer when valid & ready
//   busy                     - high whenever not in IDLE
//   err_checksum/opcode/timeout/overrun - registered one-cycle error pulses
module uart_frame_assembler
  import uart_frame_assembler_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy,
  output logic               err_checksum,
  output logic               err_opcode,
  output logic               err_timeout,
  output logic               err_overrun
);

  localparam int OPERANDS_W = 2 * OPERAND_W;

  state_t                  state_reg, state_next;
  logic [BYTE_CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [7:0]              xor_reg, xor_next;
  opcode_t                 opcode_reg, opcode_next;
  logic [OPERANDS_W-1:0]   operand_reg, operand_next;
  logic [FRAME_W-1:0]      frame_reg, frame_next;
  logic                    frame_valid_reg, frame_valid_next;
  logic                    err_checksum_reg, err_checksum_next;
  logic                    err_opcode_reg, err_opcode_next;
  logic                    err_timeout_reg, err_timeout_next;
  logic                    err_overrun_reg, err_overrun_next;

  logic in_frame;
  logic timeout_expired;

  assign in_frame = is_frame_state(state_reg);

  frame_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid || !in_frame),
    .enable (in_frame),
    .expired(timeout_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      byte_cnt_reg     <= '0;
      xor_reg          <= '0;
      opcode_reg       <= OP_ADD;
      operand_reg      <= '0;
      frame_reg        <= '0;
      frame_valid_reg  <= 1'b0;
      err_checksum_reg <= 1'b0;
      err_opcode_reg   <= 1'b0;
      err_timeout_reg  <= 1'b0;
      err_overrun_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      byte_cnt_reg     <= byte_cnt_next;
      xor_reg          <= xor_next;
      opcode_reg       <= opcode_next;
      operand_reg      <= operand_next;
      frame_reg        <= frame_next;
      frame_valid_reg  <= frame_valid_next;
      err_checksum_reg <= err_checksum_next;
      err_opcode_reg   <= err_opcode_next;
      err_timeout_reg  <= err_timeout_next;
      err_overrun_reg  <= err_overrun_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    byte_cnt_next     = byte_cnt_reg;
    xor_next          = xor_reg;
    opcode_next       = opcode_reg;
    operand_next      = operand_reg;
    frame_next        = frame_reg;
    frame_valid_next  = frame_valid_reg;
    err_checksum_next = 1'b0;
    err_opcode_next   = 1'b0;
    err_timeout_next  = 1'b0;
    err_overrun_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        byte_cnt_next = '0;
        xor_next      = '0;
        // Non-sync bytes between frames are line noise; drop quietly.
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_next = ST_OPCODE;
        end
      end

      ST_OPCODE: begin
        if (rx_valid) begin
          if (rx_data[7:OPCODE_W] != '0) begin
            err_opcode_next = 1'b1;
            state_next      = ST_IDLE;
          end else begin
            opcode_next   = opcode_t'(rx_data[OPCODE_W-1:0]);
            xor_next      = rx_data;
            byte_cnt_next = '0;
            state_next    = ST_PAYLOAD;
          end
        end else if (timeout_expired) begin
          err_timeout_next = 1'b1;
          state_next       = ST_IDLE;
        end
      end

      ST_PAYLOAD: begin
        if (rx_valid) begin
          // A sync value here is plain data; no resynchronisation.
          operand_next  = {operand_reg[OPERANDS_W-9:0], rx_data};
          xor_next      = xor_reg ^ rx_data;
          byte_cnt_next = byte_cnt_reg + BYTE_CNT_W'(1);
          if (byte_cnt_reg == BYTE_CNT_W'(PAYLOAD_BYTES - 1)) begin
            state_next = ST_CHECK;
          end
        end else if (timeout_expired) begin
          err_timeout_next = 1'b1;
          state_next       = ST_IDLE;
        end
      end

      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == xor_reg) begin
            frame_next       = {opcode_reg, operand_reg};
            frame_valid_next = 1'b1;
            state_next       = ST_HOLD;
          end else begin
            // Previously delivered frame is left untouched.
            err_checksum_next = 1'b1;
            state_next        = ST_IDLE;
          end
        end else if (timeout_expired) begin
          err_timeout_next = 1'b1;
          state_next       = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (frame_ready) begin
          frame_valid_next = 1'b0;
          state_next       = ST_IDLE;
          // The transfer cycle already behaves as IDLE for an incoming byte.
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_next = ST_OPCODE;
          end
        end else if (rx_valid) begin
          err_overrun_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign frame        = frame_reg;
  assign frame_valid  = frame_valid_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign err_checksum = err_checksum_reg;
  assign err_opcode   = err_opcode_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_overrun  = err_overrun_reg;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler (TIMEOUT_CYCLES = 16).
module tb_uart_frame_assembler;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [65:0] frame;
  logic        frame_valid;
  logic        frame_ready;
  logic        busy;
  logic        err_checksum;
  logic        err_opcode;
  logic        err_timeout;
  logic        err_overrun;

  int checks = 0;
  int fails  = 0;
  int fv_cycles  = 0;
  int err_pulses = 0;

  localparam logic [65:0] FRAME1 = {2'b01, 32'h12345678, 32'h87654321};
  localparam logic [65:0] FRAME2 = {2'b10, 32'hDEADBEEF, 32'h01020304};

  uart_frame_assembler #(
    .TIMEOUT_CYCLES(16),
    .SYNC_BYTE     (8'hA5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .err_checksum(err_checksum),
    .err_opcode  (err_opcode),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_valid cycles and error pulses, sampled just after each edge.
  always begin
    @(posedge clk);
    #1;
    if (frame_valid) fv_cycles++;
    if (err_checksum || err_opcode || err_timeout || err_overrun) err_pulses++;
  end

  function automatic logic [3:0] errs();
    return {err_checksum, err_opcode, err_timeout, err_overrun};
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one byte for exactly one cycle; called and returns on a negedge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame1(input logic [7:0] cs);
    send(8'hA5); send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h87); send(8'h65); send(8'h43); send(8'h21);
    send(cs);
  endtask

  task automatic send_frame2();
    send(8'hA5); send(8'h02);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    send(8'h24);
  endtask

  int fv0;
  int ep0;

  initial begin
    reset       = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    frame_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_frame", frame, 66'h0);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_busy",  busy, 1'b0);
    check("rst_errs",  errs(), 4'h0);
    reset = 1'b0;
    @(negedge clk);

    // Good frame, consumer ready: valid for exactly one cycle
    frame_ready = 1'b1;
    fv0 = fv_cycles;
    ep0 = err_pulses;
    send_frame1(8'h89);
    check("f1_frame", frame, FRAME1);
    check("f1_valid", frame_valid, 1'b1);
    @(negedge clk);
    check("f1_valid_drop", frame_valid, 1'b0);
    check("f1_idle", busy, 1'b0);
    @(negedge clk);
    check("f1_fv_cycles", 66'(fv_cycles - fv0), 66'd1);
    check("f1_no_errs", 66'(err_pulses - ep0), 66'd0);

    // Bad checksum
    send_frame1(8'h88);
    check("cs_err", errs(), 4'b1000);
    check("cs_valid", frame_valid, 1'b0);
    check("cs_busy", busy, 1'b0);
    check("cs_frame_kept", frame, FRAME1);
    @(negedge clk);
    check("cs_pulse_end", errs(), 4'h0);

    // Garbage in IDLE, then bad opcode
    send(8'h00);
    check("garb00_busy", busy, 1'b0);
    send(8'hFF);
    check("garbFF_busy", busy, 1'b0);
    check("garb_errs", errs(), 4'h0);
    send(8'hA5);
    check("sync_busy", busy, 1'b1);
    send(8'h04);
    check("op_err", errs(), 4'b0100);
    check("op_idle", busy, 1'b0);

    // Timeout 16 cycles after the last byte
    send(8'hA5); send(8'h01); send(8'h12);
    repeat (15) @(negedge clk);
    check("to_not_yet", errs(), 4'h0);
    check("to_busy", busy, 1'b1);
    @(negedge clk);
    check("to_err", errs(), 4'b0010);
    check("to_idle", busy, 1'b0);
    @(negedge clk);
    check("to_pulse_end", errs(), 4'h0);
    repeat (3) @(negedge clk);
    send_frame2();
    check("after_to_frame", frame, FRAME2);
    check("after_to_valid", frame_valid, 1'b1);
    @(negedge clk);

    // Byte on the expiry cycle wins over the timeout
    send(8'hA5); send(8'h01);
    repeat (15) @(negedge clk);
    send(8'h12);
    check("race_no_to", errs(), 4'h0);
    check("race_busy", busy, 1'b1);
    send(8'h34); send(8'h56); send(8'h78);
    send(8'h87); send(8'h65); send(8'h43); send(8'h21);
    send(8'h89);
    check("race_frame", frame, FRAME1);
    check("race_valid", frame_valid, 1'b1);
    @(negedge clk);

    // Overrun while holding, then sync in the transfer cycle
    frame_ready = 1'b0;
    send_frame2();
    check("hold_valid", frame_valid, 1'b1);
    send(8'h11);
    check("ovr1_err", errs(), 4'b0001);
    check("ovr1_valid", frame_valid, 1'b1);
    send(8'h22);
    check("ovr2_err", errs(), 4'b0001);
    check("ovr_frame", frame, FRAME2);
    rx_data     = 8'hA5;
    rx_valid    = 1'b1;
    frame_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("xfer_valid", frame_valid, 1'b0);
    check("xfer_busy", busy, 1'b1);
    check("xfer_errs", errs(), 4'h0);
    send(8'h04);
    check("xfer_in_opcode", errs(), 4'b0100);

    // Reset on the 5th payload byte
    send(8'hA5); send(8'h01);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    rx_data  = 8'h87;
    rx_valid = 1'b1;
    reset    = 1'b1;
    @(negedge clk);
    check("mid_rst_frame", frame, 66'h0);
    check("mid_rst_valid", frame_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_errs", errs(), 4'h0);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("post_rst_errs", errs(), 4'h0);
    send_frame1(8'h89);
    check("post_rst_frame", frame, FRAME1);
    check("post_rst_valid", frame_valid, 1'b1);
    @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
